// File: rtl/dmem_pkg.sv
// Shared constants for the data-side responder: MMIO register offsets,
// ERR bit positions and STATUS field layout.
package dmem_pkg;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_OUT    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_ERR    = 4'hC;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_UNMAP = 1;
  localparam int ERR_OVF   = 2;
  localparam int ERR_W     = 3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 8;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic [ST_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_FULL]                   = full;
    s[ST_EMPTY]                  = empty;
    s[ST_CNT_LSB +: ST_CNT_W]    = cnt;
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO is accepted
// only when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    // Head reads as zero when empty so the output is clean after reset.
    dout     = empty ? '0 : mem_q[rd_ptr_q];
    count    = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset)
      mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for the single-cycle CPU: word RAM plus an MMIO window
// holding a cycle counter, a debug output FIFO and a sticky error register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  output logic [31:0] rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]      ram_q [DEPTH_WORDS];
  logic [31:0]      cycle_q, cycle_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [31:0]      ram_off;
  logic [AW-1:0]    widx;
  logic [3:0]       moff;
  logic             acc, aligned, in_ram, in_mmio, mapped;
  logic             rd_ok, wr_ok;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;

  // Address decode and access qualification.
  always_comb begin
    ram_off = addr - DATA_BASE;
    in_ram  = (addr >= DATA_BASE) && (ram_off < RAM_BYTES);
    in_mmio = (addr[31:4] == MMIO_BASE[31:4]);
    mapped  = in_ram | in_mmio;
    widx    = ram_off[AW+1:2];
    moff    = addr[3:0];
    aligned = (addr[1:0] == 2'b00);
    acc     = DM_CS & (DM_R | DM_W);
    rd_ok   = DM_CS & DM_R & aligned & mapped;
    wr_ok   = DM_CS & DM_W & aligned & mapped & ~reset;
  end

  // Load path is purely combinational so a same-cycle write shows the old value.
  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      if (in_ram) begin
        rdata = ram_q[widx];
      end else begin
        case (moff)
          OFF_CYCLE:  rdata = cycle_q;
          OFF_STATUS: rdata = status_word(fifo_full, fifo_empty, ST_CNT_W'(fifo_cnt));
          OFF_ERR:    rdata = 32'(err_q);
          default:    rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = ~fifo_empty;
    fifo_pop  = out_valid & out_ready;
    fifo_push = wr_ok & in_mmio & (moff == OFF_OUT);
    cycle_d   = cycle_q + 32'd1;
    err_d     = err_q;
    if (wr_ok && in_mmio && moff == OFF_ERR)
      err_d = '0;
    // Sets are applied after the clear so a new error is never lost.
    if (acc && !aligned)
      err_d[ERR_ALIGN] = 1'b1;
    if (acc && !mapped)
      err_d[ERR_UNMAP] = 1'b1;
    if (fifo_push && fifo_full && !fifo_pop)
      err_d[ERR_OVF] = 1'b1;
    err = |err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      err_q   <= '0;
    end else begin
      cycle_q <= cycle_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && in_ram)
      ram_q[widx] <= wdata;
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
